serial_four_bit_subtractor: RTL and testbench



---
 rtl/serial_four_bit_subtractor_if.sv | 25 ++
 rtl/serial_four_bit_subtractor.sv | 108 ++++++++++
 tb/tb_serial_four_bit_subtractor.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_four_bit_subtractor_if.sv
// Handshake and operand/result bus of the bit-serial subtractor.
interface serial_four_bit_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Borrow_in;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Difference;
    logic             Borrow_Out;

    // Controller side: issues requests and operands, observes status and result.
    modport master (
        output Start, A, B, Borrow_in,
        input  Busy, Done, Difference, Borrow_Out
    );

    // Subtractor side.
    modport slave (
        input  Start, A, B, Borrow_in,
        output Busy, Done, Difference, Borrow_Out
    );
endinterface

// File: rtl/serial_four_bit_subtractor.sv
// Bit-serial subtractor: Difference = A - B - Borrow_in, LSB first, one bit per
// clock through a single full-subtractor cell and a borrow flip-flop.
module serial_four_bit_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    serial_four_bit_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             a_bit, b_bit, d_bit, br_nxt, last_bit, accept;

    assign a_bit    = opa_q[0];
    assign b_bit    = opb_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign accept   = bus.Start && (state_q != SHIFT);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: Start is accepted in IDLE and in DONE (back-to-back).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start) state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    state_d = bus.Start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        bus.Busy       = (state_q == SHIFT);
        bus.Done       = (state_q == DONE);
        bus.Difference = diff_q;
        bus.Borrow_Out = bout_q;
    end

    // Datapath next values. The minuend register doubles as the result register:
    // each difference bit enters at the MSB as the consumed minuend bit leaves at
    // the LSB, so after WIDTH shifts it holds the complete difference.
    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        if (accept) begin
            opa_d = bus.A;
            opb_d = bus.B;
            br_d  = bus.Borrow_in;
            cnt_d = '0;
        end else if (state_q == SHIFT) begin
            opa_d = {d_bit, opa_q[WIDTH-1:1]};
            opb_d = {1'b0, opb_q[WIDTH-1:1]};
            br_d  = br_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
                diff_d = {d_bit, opa_q[WIDTH-1:1]};
                bout_d = br_nxt;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            opa_q  <= '0;
            opb_q  <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end
endmodule

// File: tb/tb_serial_four_bit_subtractor.sv
// Self-checking bench for the bit-serial subtractor: table of operand vectors
// plus hand-written sequences for ignored Start, back-to-back and mid-op reset.
module tb_serial_four_bit_subtractor;
    localparam int W = 4;

    logic Clk;
    logic Reset;

    serial_four_bit_subtractor_if #(.WIDTH(W)) bus ();

    serial_four_bit_subtractor #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [W:0] sb_q[$];   // {Borrow_Out, Difference} expected per Done pulse

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every Done pulse pops one expected result.
    always @(negedge Clk) begin
        if (bus.Done) begin
            logic [W:0] e;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("difference", int'(bus.Difference), int'(e[W-1:0]));
                check("borrow_out", int'(bus.Borrow_Out), int'(e[W]));
                check("busy_in_done", int'(bus.Busy), 0);
            end
        end
    end

    // Runs one operation from a negedge; checks Busy, result hold, latency and pulse width.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb,
                          input logic [W-1:0] prev_d, input logic prev_b);
        int n;
        bit got;
        n = 0;
        got = 0;
        bus.A = a;
        bus.B = b;
        bus.Borrow_in = bin;
        bus.Start = 1'b1;
        sb_q.push_back({eb, ed});
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            n++;
            if (i == 0) begin
                bus.Start = 1'b0;
                bus.A = W'($urandom);
                bus.B = W'($urandom);
                bus.Borrow_in = 1'($urandom);
            end
            if (bus.Done) begin
                got = 1;
                break;
            end
            check("busy_high", int'(bus.Busy), 1);
            check("diff_hold", int'(bus.Difference), int'(prev_d));
            check("bout_hold", int'(bus.Borrow_Out), int'(prev_b));
        end
        check("done_seen", int'(got), 1);
        check("latency", n, W + 1);
        @(negedge Clk);
        check("done_one_cycle", int'(bus.Done), 0);
        check("idle_busy_low", int'(bus.Busy), 0);
    endtask

    vec_t tbl[10];
    logic [W-1:0] prev_d;
    logic         prev_b;

    initial begin
        int n;
        bit got;
        tbl[0] = '{a: 4'd0,  b: 4'd0,  bin: 1'b0, d: 4'd0,  bo: 1'b0};
        tbl[1] = '{a: 4'd3,  b: 4'd1,  bin: 1'b0, d: 4'd2,  bo: 1'b0};
        tbl[2] = '{a: 4'd12, b: 4'd4,  bin: 1'b0, d: 4'd8,  bo: 1'b0};
        tbl[3] = '{a: 4'd4,  b: 4'd4,  bin: 1'b1, d: 4'd15, bo: 1'b1};
        tbl[4] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, d: 4'd0,  bo: 1'b1};
        tbl[5] = '{a: 4'd7,  b: 4'd5,  bin: 1'b0, d: 4'd2,  bo: 1'b0};
        tbl[6] = '{a: 4'd5,  b: 4'd9,  bin: 1'b0, d: 4'd12, bo: 1'b1};
        tbl[7] = '{a: 4'd15, b: 4'd15, bin: 1'b1, d: 4'd15, bo: 1'b1};
        tbl[8] = '{a: 4'd15, b: 4'd0,  bin: 1'b1, d: 4'd14, bo: 1'b0};
        tbl[9] = '{a: 4'd10, b: 4'd3,  bin: 1'b1, d: 4'd6,  bo: 1'b0};

        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Borrow_in = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_busy", int'(bus.Busy), 0);
        check("rst_done", int'(bus.Done), 0);
        check("rst_diff", int'(bus.Difference), 0);
        check("rst_bout", int'(bus.Borrow_Out), 0);
        Reset = 1'b0;
        @(negedge Clk);

        prev_d = '0;
        prev_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, prev_d, prev_b);
            prev_d = tbl[i].d;
            prev_b = tbl[i].bo;
        end

        // Start during Busy is ignored: 9-2 completes, 1-7 never runs.
        bus.A = 4'd9;
        bus.B = 4'd2;
        bus.Borrow_in = 1'b0;
        bus.Start = 1'b1;
        sb_q.push_back({1'b0, 4'd7});
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        bus.A = 4'd1;
        bus.B = 4'd7;
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (8) @(negedge Clk);
        check("ignored_start_drained", sb_q.size(), 0);
        check("ignored_start_diff", int'(bus.Difference), 7);

        // Start held high: back-to-back 8-3 then 5-6.
        bus.A = 4'd8;
        bus.B = 4'd3;
        bus.Borrow_in = 1'b0;
        bus.Start = 1'b1;
        sb_q.push_back({1'b0, 4'd5});
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (bus.Done) begin
                got = 1;
                break;
            end
        end
        check("b2b_first_done", int'(got), 1);
        bus.A = 4'd5;
        bus.B = 4'd6;
        sb_q.push_back({1'b1, 4'd15});
        n = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            n++;
            if (i == 0) bus.Start = 1'b0;
            if (bus.Done) begin
                got = 1;
                break;
            end
        end
        check("b2b_second_done", int'(got), 1);
        check("b2b_spacing", n, W + 1);
        repeat (3) @(negedge Clk);
        check("b2b_drained", sb_q.size(), 0);

        // Asynchronous reset in the middle of SHIFT aborts without a Done.
        bus.A = 4'd9;
        bus.B = 4'd1;
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        check("pre_rst_busy", int'(bus.Busy), 1);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_busy", int'(bus.Busy), 0);
        check("arst_done", int'(bus.Done), 0);
        check("arst_diff", int'(bus.Difference), 0);
        check("arst_bout", int'(bus.Borrow_Out), 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        check("arst_no_done", sb_q.size(), 0);
        run_op(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0);

        check("final_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard wall-clock bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (bad=%0d)", bad);
        $fatal(1, "timeout");
    end
endmodule
